mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// CPU-to-RAM access controller: sequences byte/halfword/word accesses and splits
// doublewords into two word accesses, with alignment checking and a WAIT timeout.
module mem_access_ctrl #(
   parameter int TIMEOUT = 15
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req,
   input  logic        i_rw,
   input  logic [7:0]  i_addr,
   input  logic [1:0]  i_dtype,
   input  logic        i_sign,
   input  logic [63:0] i_wdata,
   output logic [63:0] o_rdata,
   output logic        o_done,
   output logic        o_err,
   output logic        o_busy,
   output logic        o_mov,
   output logic        o_read_write,
   output logic [7:0]  o_address,
   output logic [31:0] o_data_in,
   output logic [1:0]  o_data_type,
   output logic        o_sign,
   input  logic [31:0] i_data_out,
   input  logic        i_moc
);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ISSUE, S_WAIT, S_DONE} state_t;

   localparam logic [3:0] TO_L = 4'(TIMEOUT);

   state_t      r_state;
   logic        r_rw;
   logic [7:0]  r_addr;
   logic [1:0]  r_dtype;
   logic        r_sign;
   logic [63:0] r_wdata;
   logic        r_half;
   logic [3:0]  r_cnt;
   logic [31:0] r_hi;

   logic        w_misaligned;
   logic        w_is_dword;
   logic [3:0]  w_cnt_inc;
   logic        w_src_rw;
   logic [7:0]  w_src_addr;
   logic [1:0]  w_src_dtype;
   logic        w_src_sign;
   logic [63:0] w_src_wdata;
   logic        w_src_half;
   logic [7:0]  w_ram_addr;
   logic [1:0]  w_ram_dtype;
   logic [31:0] w_ram_data;
   logic [31:0] w_ext;

   assign w_misaligned = ((i_dtype == 2'b01) && i_addr[0]) ||
                         (i_dtype[1] && (i_addr[1:0] != 2'b00));
   assign w_is_dword   = (r_dtype == 2'b11);
   assign w_cnt_inc    = r_cnt + 4'd1;

   // RAM-side values loaded on entry to SETUP: from the CPU inputs when coming from IDLE,
   // from the latched request when starting the second doubleword half.
   assign w_src_rw    = (r_state == S_IDLE) ? i_rw    : r_rw;
   assign w_src_addr  = (r_state == S_IDLE) ? i_addr  : r_addr;
   assign w_src_dtype = (r_state == S_IDLE) ? i_dtype : r_dtype;
   assign w_src_sign  = (r_state == S_IDLE) ? i_sign  : r_sign;
   assign w_src_wdata = (r_state == S_IDLE) ? i_wdata : r_wdata;
   assign w_src_half  = (r_state == S_IDLE) ? 1'b0    : 1'b1;
   assign w_ram_addr  = w_src_half ? (w_src_addr + 8'd4) : w_src_addr;
   assign w_ram_dtype = (w_src_dtype == 2'b11) ? 2'b10 : w_src_dtype;
   assign w_ram_data  = (w_src_dtype != 2'b11) ? w_src_wdata[31:0] :
                        (w_src_half ? w_src_wdata[31:0] : w_src_wdata[63:32]);

   // Extension of narrow read data from the RAM word
   always_comb begin
      w_ext = i_data_out;
      case (r_dtype)
         2'b00:   w_ext = r_sign ? {{24{i_data_out[7]}}, i_data_out[7:0]}
                                 : {24'd0, i_data_out[7:0]};
         2'b01:   w_ext = r_sign ? {{16{i_data_out[15]}}, i_data_out[15:0]}
                                 : {16'd0, i_data_out[15:0]};
         default: w_ext = i_data_out;
      endcase
   end

   // Access sequencer with registered CPU- and RAM-side outputs
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_rw         <= 1'b0;
         r_addr       <= 8'd0;
         r_dtype      <= 2'b00;
         r_sign       <= 1'b0;
         r_wdata      <= 64'd0;
         r_half       <= 1'b0;
         r_cnt        <= 4'd0;
         r_hi         <= 32'd0;
         o_rdata      <= 64'd0;
         o_done       <= 1'b0;
         o_err        <= 1'b0;
         o_busy       <= 1'b0;
         o_mov        <= 1'b0;
         o_read_write <= 1'b0;
         o_address    <= 8'd0;
         o_data_in    <= 32'd0;
         o_data_type  <= 2'b00;
         o_sign       <= 1'b0;
      end else begin
         o_done <= 1'b0;
         o_err  <= 1'b0;
         o_mov  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_req) begin
                  r_rw    <= i_rw;
                  r_addr  <= i_addr;
                  r_dtype <= i_dtype;
                  r_sign  <= i_sign;
                  r_wdata <= i_wdata;
                  r_half  <= 1'b0;
                  r_cnt   <= 4'd0;
                  o_busy  <= 1'b1;
                  if (w_misaligned) begin
                     r_state <= S_DONE;
                     o_done  <= 1'b1;
                     o_err   <= 1'b1;
                  end else begin
                     r_state      <= S_SETUP;
                     o_read_write <= w_src_rw;
                     o_address    <= w_ram_addr;
                     o_data_in    <= w_ram_data;
                     o_data_type  <= w_ram_dtype;
                     o_sign       <= w_src_sign;
                  end
               end
            end
            S_SETUP: begin
               r_state <= S_ISSUE;
               o_mov   <= 1'b1;
            end
            S_ISSUE: r_state <= S_WAIT;
            S_WAIT: begin
               if (i_moc) begin
                  r_cnt <= 4'd0;
                  if (w_is_dword && !r_half) begin
                     r_half       <= 1'b1;
                     r_state      <= S_SETUP;
                     o_read_write <= w_src_rw;
                     o_address    <= w_ram_addr;
                     o_data_in    <= w_ram_data;
                     o_data_type  <= w_ram_dtype;
                     o_sign       <= w_src_sign;
                     if (r_rw) begin
                        r_hi <= i_data_out;
                     end
                  end else begin
                     r_state <= S_DONE;
                     o_done  <= 1'b1;
                     // First doubleword half is staged so a timeout never leaves RData half-updated
                     if (r_rw) begin
                        o_rdata <= w_is_dword ? {r_hi, i_data_out} : {32'd0, w_ext};
                     end
                  end
               end else if (w_cnt_inc == TO_L) begin
                  r_cnt   <= 4'd0;
                  r_state <= S_DONE;
                  o_done  <= 1'b1;
                  o_err   <= 1'b1;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               o_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               o_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: byte-addressed little-endian RAM model,
// table of accesses with hand-computed results, plus timeout/reset/busy sequences.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic        rw;
   logic [7:0]  addr;
   logic [1:0]  dtype;
   logic        sign;
   logic [63:0] wdata;
   logic [63:0] rdata;
   logic        done, err, busy, mov, ram_rw, ram_sign;
   logic [7:0]  ram_addr;
   logic [31:0] ram_din;
   logic [1:0]  ram_dt;
   logic [31:0] ram_dout;
   logic        moc;
   logic        moc_en;
   logic [7:0]  mem [256];

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   mem_access_ctrl #(.TIMEOUT(15)) dut (
      .i_clk(clk), .i_reset(rst), .i_req(req), .i_rw(rw), .i_addr(addr),
      .i_dtype(dtype), .i_sign(sign), .i_wdata(wdata), .o_rdata(rdata),
      .o_done(done), .o_err(err), .o_busy(busy), .o_mov(mov),
      .o_read_write(ram_rw), .o_address(ram_addr), .o_data_in(ram_din),
      .o_data_type(ram_dt), .o_sign(ram_sign), .i_data_out(ram_dout), .i_moc(moc)
   );

   function automatic logic [31:0] ram_read(input logic [7:0] a, input logic [1:0] dt, input logic sg);
      logic [31:0] w;
      w = {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
      case (dt)
         2'b00:   return sg ? {{24{w[7]}}, w[7:0]} : {24'd0, w[7:0]};
         2'b01:   return sg ? {{16{w[15]}}, w[15:0]} : {16'd0, w[15:0]};
         default: return w;
      endcase
   endfunction

   // RAM model: answers one cycle after the MOV strobe
   always @(posedge clk) begin
      moc <= 1'b0;
      if (mov && moc_en) begin
         moc <= 1'b1;
         if (ram_rw) begin
            ram_dout <= ram_read(ram_addr, ram_dt, ram_sign);
         end else begin
            mem[ram_addr] <= ram_din[7:0];
            if (ram_dt != 2'b00) mem[ram_addr + 8'd1] <= ram_din[15:8];
            if (ram_dt[1]) begin
               mem[ram_addr + 8'd2] <= ram_din[23:16];
               mem[ram_addr + 8'd3] <= ram_din[31:24];
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic run_access(input logic i_rw, input logic [7:0] a, input logic [1:0] dt,
                             input logic sg, input logic [63:0] wd,
                             output int lat, output logic er, output logic [63:0] rd,
                             output int movs, output logic [7:0] maddr);
      @(negedge clk);
      req = 1'b1; rw = i_rw; addr = a; dtype = dt; sign = sg; wdata = wd;
      @(posedge clk);
      #1 req = 1'b0;
      lat = 0; movs = 0; er = 1'b0; rd = 64'd0; maddr = 8'd0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (mov) begin
            movs++;
            maddr = ram_addr;
         end
         if (done) begin
            lat = k; er = err; rd = rdata;
            break;
         end
         @(posedge clk);
      end
   endtask

   typedef struct {
      logic        rw;
      logic [7:0]  addr;
      logic [1:0]  dt;
      logic        sg;
      logic [63:0] wd;
      int          lat;
      logic        er;
      logic [63:0] rd;
      int          movs;
      logic [7:0]  maddr;
   } vec_t;

   vec_t vecs [14];

   initial begin
      int lat, movs, dcnt;
      logic er;
      logic [63:0] rd;
      logic [7:0] maddr;

      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      ram_dout = 32'd0; moc = 1'b0; moc_en = 1'b1;
      req = 1'b0; rw = 1'b0; addr = 8'd0; dtype = 2'b00; sign = 1'b0; wdata = 64'd0;

      //          rw    addr    dt     sg    wdata                   lat er    rdata                   movs maddr
      vecs[0]  = '{1'b0, 8'h10, 2'b10, 1'b0, 64'h00000000_DEADBEEF, 4, 1'b0, 64'h00000000_00000000, 1, 8'h10};
      vecs[1]  = '{1'b1, 8'h10, 2'b10, 1'b0, 64'h0,                 4, 1'b0, 64'h00000000_DEADBEEF, 1, 8'h10};
      vecs[2]  = '{1'b0, 8'h20, 2'b00, 1'b0, 64'h00000000_00000080, 4, 1'b0, 64'h00000000_DEADBEEF, 1, 8'h20};
      vecs[3]  = '{1'b1, 8'h20, 2'b00, 1'b1, 64'h0,                 4, 1'b0, 64'h00000000_FFFFFF80, 1, 8'h20};
      vecs[4]  = '{1'b1, 8'h20, 2'b00, 1'b0, 64'h0,                 4, 1'b0, 64'h00000000_00000080, 1, 8'h20};
      vecs[5]  = '{1'b0, 8'hFC, 2'b11, 1'b0, 64'h11223344_55667788, 7, 1'b0, 64'h00000000_00000080, 2, 8'h00};
      vecs[6]  = '{1'b1, 8'hFC, 2'b11, 1'b0, 64'h0,                 7, 1'b0, 64'h11223344_55667788, 2, 8'h00};
      vecs[7]  = '{1'b1, 8'h00, 2'b10, 1'b0, 64'h0,                 4, 1'b0, 64'h00000000_55667788, 1, 8'h00};
      vecs[8]  = '{1'b1, 8'hFC, 2'b10, 1'b0, 64'h0,                 4, 1'b0, 64'h00000000_11223344, 1, 8'hFC};
      vecs[9]  = '{1'b1, 8'h03, 2'b01, 1'b0, 64'h0,                 1, 1'b1, 64'h00000000_11223344, 0, 8'h00};
      vecs[10] = '{1'b0, 8'h02, 2'b10, 1'b0, 64'h0,                 1, 1'b1, 64'h00000000_11223344, 0, 8'h00};
      vecs[11] = '{1'b0, 8'h22, 2'b01, 1'b0, 64'h00000000_00008001, 4, 1'b0, 64'h00000000_11223344, 1, 8'h22};
      vecs[12] = '{1'b1, 8'h22, 2'b01, 1'b1, 64'h0,                 4, 1'b0, 64'h00000000_FFFF8001, 1, 8'h22};
      vecs[13] = '{1'b1, 8'h06, 2'b11, 1'b0, 64'h0,                 1, 1'b1, 64'h00000000_FFFF8001, 0, 8'h00};

      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_busy", {63'd0, busy}, 64'd0);
      check("reset_done", {63'd0, done}, 64'd0);
      check("reset_mov", {63'd0, mov}, 64'd0);
      check("reset_rdata", rdata, 64'd0);
      check("reset_address", {56'd0, ram_addr}, 64'd0);
      rst = 1'b0;

      for (int v = 0; v < 14; v++) begin
         run_access(vecs[v].rw, vecs[v].addr, vecs[v].dt, vecs[v].sg, vecs[v].wd, lat, er, rd, movs, maddr);
         check($sformatf("v%0d_latency", v), 64'(lat), 64'(vecs[v].lat));
         check($sformatf("v%0d_err", v), {63'd0, er}, {63'd0, vecs[v].er});
         check($sformatf("v%0d_rdata", v), rd, vecs[v].rd);
         check($sformatf("v%0d_movs", v), 64'(movs), 64'(vecs[v].movs));
         if (vecs[v].movs > 0) check($sformatf("v%0d_ram_addr", v), {56'd0, maddr}, {56'd0, vecs[v].maddr});
      end

      // Timeout: RAM never answers
      moc_en = 1'b0;
      run_access(1'b1, 8'h10, 2'b10, 1'b0, 64'h0, lat, er, rd, movs, maddr);
      check("timeout_latency", 64'(lat), 64'd18);
      check("timeout_err", {63'd0, er}, 64'd1);
      check("timeout_rdata", rd, 64'h00000000_FFFF8001);
      moc_en = 1'b1;

      // Req held high while busy is not queued
      @(negedge clk);
      req = 1'b1; rw = 1'b1; addr = 8'h10; dtype = 2'b10; sign = 1'b0;
      repeat (4) @(posedge clk);
      #1 req = 1'b0;
      @(negedge clk);
      check("held_req_done", {63'd0, done}, 64'd1);
      check("held_req_rdata", rdata, 64'h00000000_DEADBEEF);
      dcnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (done || busy) dcnt++;
      end
      check("held_req_no_requeue", 64'(dcnt), 64'd0);

      // Reset in WAIT aborts without a Done pulse
      moc_en = 1'b0;
      @(negedge clk);
      req = 1'b1; rw = 1'b1; addr = 8'h10; dtype = 2'b10;
      @(posedge clk);
      #1 req = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("pre_reset_busy", {63'd0, busy}, 64'd1);
      rst = 1'b1;
      @(negedge clk);
      check("abort_busy", {63'd0, busy}, 64'd0);
      check("abort_mov", {63'd0, mov}, 64'd0);
      check("abort_done", {63'd0, done}, 64'd0);
      check("abort_rdata", rdata, 64'd0);
      rst = 1'b0;
      moc_en = 1'b1;
      dcnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (done || mov || busy) dcnt++;
      end
      check("abort_quiet", 64'(dcnt), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
